// File: rtl/secure_memory_responder.sv
// Avalon-MM responder for the secure memory array: bytes are XOR-scrambled at rest and the
// whole array is cleared after reset. Define SECURE_MEMORY_RANGE_CHECK_EN to fault upper address bits.
module secure_memory_responder #(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [31:0] SCRAMBLE_KEY = 32'hC3A5_5A3C,
  parameter logic [31:0] ERR_PATTERN  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [15:0] address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic        init_done,
  output logic        range_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic [31:0]       readdata_q;
  logic              readdatavalid_q;
  logic              waitrequest_q;
  logic              init_done_q;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              out_of_range;

  assign idx = address[ADDR_W-1:0];

`ifdef SECURE_MEMORY_RANGE_CHECK_EN
  logic range_err_q;

  assign out_of_range = |address[15:ADDR_W];
  assign range_err    = range_err_q;
`else
  // Upper address bits alias onto the array and the error pattern is never returned.
  logic unused_cfg;

  assign out_of_range = 1'b0;
  assign range_err    = 1'b0;
  assign unused_cfg   = ^{address[15:ADDR_W], ERR_PATTERN};
`endif

  // Single memory write port, shared by the clear sequencer and bus writes.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = idx;
    mem_wdata = writedata ^ SCRAMBLE_KEY;
    mem_be    = byteenable;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = init_cnt_q;
      mem_wdata = SCRAMBLE_KEY;
      mem_be    = 4'hF;
    end else if (chipselect && write && !out_of_range) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset; the clear sequencer zeroes it, and a reset here would stop RAM inference.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: state and outputs update with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_INIT;
      init_cnt_q      <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      waitrequest_q   <= 1'b1;
      init_done_q     <= 1'b0;
`ifdef SECURE_MEMORY_RANGE_CHECK_EN
      range_err_q     <= 1'b0;
`endif
    end else begin
      readdatavalid_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (&init_cnt_q) begin
            state_q       <= ST_READY;
            waitrequest_q <= 1'b0;
            init_done_q   <= 1'b1;
          end
        end
        ST_READY: begin
          if (chipselect) begin
            if (!write) begin
              readdatavalid_q <= 1'b1;
              readdata_q      <= mem[idx] ^ SCRAMBLE_KEY;
            end
`ifdef SECURE_MEMORY_RANGE_CHECK_EN
            if (out_of_range) begin
              range_err_q <= 1'b1;
              if (!write) readdata_q <= ERR_PATTERN;
            end
`endif
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign waitrequest   = waitrequest_q;
  assign init_done     = init_done_q;

endmodule

// File: doc/secure_memory_responder.md
Name: secure_memory_responder

Overview:
- Avalon-MM responder holding the secure memory array that the secure-memory custom-instruction initiator reads and writes.
- Data is scrambled at rest: each enabled byte is stored XORed with a key byte and unscrambled on read, so the bus sees transparent data.
- After reset, a sequencer clears every word before any access is accepted.
- Timing is fixed to suit the initiator: writes complete in one cycle, reads return one cycle after the request.

Parameters:
- ADDR_W, 10, word-address bits used for indexing; DEPTH = 2**ADDR_W words.
- SCRAMBLE_KEY, 32'hC3A5_5A3C, at-rest XOR key; byte lane i uses SCRAMBLE_KEY[8i+7:8i].
- ERR_PATTERN, 32'hDEAD_BEEF, read data returned on a range-check fault (only with the optional feature).

Ports:
- clk  input  1  clock
- reset  input  1  reset
- chipselect  input  1  request valid
- write  input  1  1 = write, 0 = read (only when chipselect = 1)
- address  input  16  word address
- byteenable  input  4  byte lanes for writes; ignored on reads
- writedata  input  32  write data
- readdata  output  32  read data, registered
- readdatavalid  output  1  one-cycle pulse, readdata valid
- waitrequest  output  1  high while not accepting requests
- init_done  output  1  array cleared, responder ready
- range_err  output  1  sticky out-of-range flag (tied 0 without the optional feature)

Interface (already decided): reset reset, asynchronous, active-high; clock clk.

Behaviour:
- Reset values: waitrequest=1, readdata=0, readdatavalid=0, init_done=0, range_err=0; FSM=INIT; init counter=0.
- FSM states: INIT, READY.
- INIT:
  - Each cycle writes SCRAMBLE_KEY (so the word reads back 0) to word[counter], then increments the counter.
  - After the write to DEPTH-1, moves to READY; exactly DEPTH cycles spent in INIT.
  - waitrequest=1 throughout; any request is ignored with no state change and no readdatavalid.
- READY: waitrequest=0, init_done=1; the FSM stays in READY until reset.
- Write (chipselect=1, write=1):
  - At the clock edge, each lane with byteenable[i]=1 stores writedata byte i XOR key byte i.
  - Other lanes are unchanged; byteenable=0000 is a no-op.
  - No readdatavalid is produced.
- Read (chipselect=1, write=0) in cycle N:
  - At the end of cycle N, readdata registers stored word XOR SCRAMBLE_KEY.
  - readdatavalid=1 for cycle N+1 only.
  - readdata holds its value until the next read.
- Index is address[ADDR_W-1:0]; address bits above ADDR_W are handled per the optional feature.
- At most one transaction per cycle; back-to-back transactions are accepted every cycle.
- Write in cycle N, read of the same word in N+1: returns the new data (no bypass needed; write lands at edge N).
- Read in cycle N, write to the same word in N+1: read returns the old data.
- Consecutive reads: readdatavalid stays high continuously; each cycle carries the data for the preceding request.
- Reset asserted mid-INIT or mid-read:
  - All outputs return to reset values immediately (asynchronous).
  - Any pending readdatavalid is cancelled.
  - INIT restarts from word 0 after reset deasserts.

Optional Feature:
- Macro: SECURE_MEMORY_RANGE_CHECK_EN.
- Defined: a request with any address bit at position ADDR_W or above set is out of range.
  - Write: dropped, memory unchanged.
  - Read: readdata=ERR_PATTERN with the normal readdatavalid pulse.
  - Either case sets range_err=1, cleared only by reset.
- Undefined:
  - Upper address bits are ignored, so addresses alias modulo DEPTH.
  - range_err is tied 0.

Test Plan:
- Reset, then idle: init_done rises after exactly 1024 cycles (ADDR_W=10) with waitrequest high until then; reads of 0x0000 and 0x03FF return 0x0000_0000.
- Write 0x1234_5678 to 0x0003, be=1111, then read 0x0003 in the next cycle: readdatavalid high one cycle later, readdata=0x1234_5678.
- Then write 0xAAAA_BBBB to 0x0003 with be=0011, and read back: 0x1234_BBBB; a write with be=0000 leaves the word unchanged.
- Assert reset at INIT cycle 500 after writes were made pre-reset: outputs reset immediately; init_done takes a full 1024 cycles again; all words read 0.
- Back-to-back reads of 0x0001, 0x0002, 0x0003 preloaded with 1, 2, 3: readdatavalid high three consecutive cycles carrying 1, 2, 3 in order.
- Write 0x5555_5555 to address 0x0400:
  - With SECURE_MEMORY_RANGE_CHECK_EN: the write is dropped, word 0 stays 0, a read of 0x0400 returns 0xDEAD_BEEF, and range_err=1 and stays set.
  - Without it: word 0 reads 0x5555_5555 and range_err=0.
